// File: rtl/mul_sequencer_if.sv
// Purpose : handshake/data bundle between the instruction decoder and the
//           multi-cycle multiply sequencer.
// Ports   : master = decoder side (drives start/operands/abort, sees status
//           and product); slave = mul_sequencer.
interface mul_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             is_signed;
  logic             abort;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic             overflow;

  modport master (
    output start, op_a, op_b, is_signed, abort,
    input  busy, stall, done, prod_lo, prod_hi, overflow
  );

  modport slave (
    input  start, op_a, op_b, is_signed, abort,
    output busy, stall, done, prod_lo, prod_hi, overflow
  );
endinterface

// File: rtl/mul_sequencer.sv
// Purpose : shift-add multiply controller for MUL R/I; stalls the core until
//           the 2*WIDTH product is ready, then pulses done for one cycle.
// Ports   : clk, rst_n (async active-low); bus (slave) carries start/op_a/
//           op_b/is_signed/abort in, busy/stall/done/prod_lo/prod_hi/overflow out.
// Latency : done WIDTH/STEP_BITS+1 cycles after the start cycle; with
//           MUL_EARLY_EXIT_EN defined RUN ends as soon as the remaining
//           multiplier is zero (minimum 2 cycles). STEP_BITS must be 1 or 2
//           and divide WIDTH.
module mul_sequencer #(
  parameter int WIDTH     = 16,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_sequencer_if.slave   bus
);

  localparam int NSTEP = WIDTH / STEP_BITS;
  localparam int CW    = $clog2(NSTEP + 1);

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

  state_t               state_q,   state_d;
  logic [2*WIDTH-1:0]   mcand_q,   mcand_d;   // multiplicand, pre-shifted to the current weight
  logic [WIDTH-1:0]     mplier_q,  mplier_d;  // multiplier, low bits are the next step
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [CW-1:0]        cnt_q,     cnt_d;     // RUN steps still to retire
  logic                 sign_q,    sign_d;
  logic                 signed_q,  signed_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [WIDTH-1:0]     prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0]     prod_hi_q, prod_hi_d;
  logic                 ovf_q,     ovf_d;

  logic                 accept;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   res;

  // Sum of the multiplicand shifted by each set bit of one step's slice.
  function automatic logic [2*WIDTH-1:0] partial(input logic [2*WIDTH-1:0] mc,
                                                 input logic [STEP_BITS-1:0] bits);
    logic [2*WIDTH-1:0] pp;
    pp = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (bits[i]) pp = pp + (mc << i);
    end
    return pp;
  endfunction

  // An abort in the start cycle cancels the request outright.
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start && !bus.abort;
  // Magnitudes as unsigned WIDTH-bit values: -(2^(WIDTH-1)) maps to 2^(WIDTH-1).
  assign a_mag  = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign b_mag  = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    signed_d  = signed_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    ovf_d     = ovf_q;
    res       = sign_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (accept) begin
          // The first step is retired in the accept cycle so that RUN plus
          // FIN fit inside the WIDTH/STEP_BITS+1 cycle budget.
          sign_d   = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          signed_d = bus.is_signed;
          acc_d    = partial({{WIDTH{1'b0}}, a_mag}, b_mag[STEP_BITS-1:0]);
          mcand_d  = {{WIDTH{1'b0}}, a_mag} << STEP_BITS;
          mplier_d = b_mag >> STEP_BITS;
          cnt_d    = CW'(NSTEP - 1);
          busy_d   = 1'b1;
          if ((NSTEP == 1) || (EARLY_EXIT && (mplier_d == '0))) state_d = S_FIN;
          else                                                   state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d    = acc_q + partial(mcand_q, mplier_q[STEP_BITS-1:0]);
          mcand_d  = mcand_q << STEP_BITS;
          mplier_d = mplier_q >> STEP_BITS;
          cnt_d    = cnt_q - CW'(1);
          if ((cnt_q == CW'(1)) || (EARLY_EXIT && (mplier_d == '0))) state_d = S_FIN;
        end
      end

      S_FIN: begin
        busy_d = 1'b0;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          prod_lo_d = res[WIDTH-1:0];
          prod_hi_d = res[2*WIDTH-1:WIDTH];
          ovf_d     = signed_q ? (res[2*WIDTH-1:WIDTH] != {WIDTH{res[WIDTH-1]}})
                               : (res[2*WIDTH-1:WIDTH] != '0);
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      signed_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      signed_q  <= signed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      ovf_q     <= ovf_d;
    end
  end

  // busy spans RUN and FIN so stall stays high through the cycle before done.
  assign bus.busy     = busy_q;
  assign bus.stall    = busy_q | accept;
  assign bus.done     = done_q;
  assign bus.prod_lo  = prod_lo_q;
  assign bus.prod_hi  = prod_hi_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Purpose : self-checking bench for mul_sequencer (directed + random operands).
// Model   : products from plain integer multiplication; latency from the
//           operand bit length (early exit) or the fixed step count.
module tb_mul_sequencer;

  localparam int W = 16;
  localparam int S = 1;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W), .STEP_BITS(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    return pa * pb;
  endfunction

  function automatic bit ref_ovf(input longint p, input bit s);
    if (s) return (p < -32768) || (p > 32767);
    return p > 65535;
  endfunction

  function automatic int ref_latency(input logic [W-1:0] b, input bit s);
    int mb, bits;
    mb   = (s && b[W-1]) ? -int'($signed(b)) : int'(b);
    bits = 0;
    while (mb != 0) begin
      bits++;
      mb = mb >> 1;
    end
    return EARLY ? ((bits < 1 ? 1 : bits) + 1) : (W / S + 1);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Issues start in the current cycle and follows the op to its done cycle.
  // poke>0 re-pulses start (with other operands) in that RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int poke);
    int lat;
    bit bad;
    longint p;
    logic [63:0] pv;
    bus.op_a = a; bus.op_b = b; bus.is_signed = s; bus.start = 1'b1;
    #1;
    bad = !bus.stall;
    lat = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      bus.start = (cyc == poke);
      if (cyc == poke) begin
        bus.op_a = ~a; bus.op_b = ~b;
      end
      @(negedge clk);
      if (bus.done) begin
        lat = cyc;
        break;
      end
      if (!bus.stall || !bus.busy) bad = 1'b1;
    end
    p  = ref_prod(a, b, s);
    pv = p;
    check("latency", 64'(lat), 64'(ref_latency(b, s)));
    check("inflight_stall_busy", 64'(bad), 64'd0);
    check("prod_lo", 64'(bus.prod_lo), 64'(pv[15:0]));
    check("prod_hi", 64'(bus.prod_hi), 64'(pv[31:16]));
    check("overflow", 64'(bus.overflow), 64'(ref_ovf(p, s)));
    check("stall_at_done", 64'(bus.stall), 64'd0);
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    bit rs;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.is_signed = 1'b0; bus.abort = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod", 64'({bus.prod_hi, bus.prod_lo}), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed operand cases.
    run_op(16'h1234, 16'h0010, 1'b0, 0);
    idle(1);
    run_op(16'hFFFD, 16'h0005, 1'b1, 0);
    idle(1);
    run_op(16'h8000, 16'h8000, 1'b1, 0);
    idle(1);
    run_op(16'h8000, 16'h0001, 1'b1, 0);
    idle(1);
    run_op(16'h0005, 16'h0003, 1'b0, 0);
    idle(1);
    run_op(16'h0009, 16'h0000, 1'b0, 0);
    idle(1);

    // Back-to-back start in the DONE cycle, then a stray start mid-RUN.
    run_op(16'h0011, 16'h0022, 1'b0, 0);
    run_op(16'h0002, 16'h0003, 1'b0, 0);
    idle(1);
    run_op(16'h00AB, 16'h0107, 1'b1, 4);
    idle(1);

    // Abort in the start cycle: request dropped.
    bus.op_a = 16'd9; bus.op_b = 16'd9; bus.is_signed = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", 64'(bus.busy), 64'd0);
    count_dones(25, dones);
    check("abort_start_no_done", 64'(dones), 64'd0);
    @(posedge clk); #1;

    // Abort at RUN cycle 8: no done, product outputs keep 2*3.
    run_op(16'd2, 16'd3, 1'b0, 0);
    idle(1);
    bus.op_a = 16'd100; bus.op_b = 16'd100; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle(7);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    count_dones(25, dones);
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_keep_lo", 64'(bus.prod_lo), 64'd6);
    @(posedge clk); #1;
    run_op(16'd100, 16'd100, 1'b0, 0);
    idle(1);

    // Randomised operands, occasional back-to-back and stray starts.
    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = pick();
      rs = 1'($urandom % 2);
      run_op(ra, rb, rs, ($urandom % 4 == 0) ? 1 : 0);
      if ($urandom % 2 == 0) idle(1 + int'($urandom % 3));
    end
    idle(1);

    // Reset in the middle of RUN.
    bus.op_a = 16'd7; bus.op_b = 16'd9; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle(4);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_prod", 64'({bus.prod_hi, bus.prod_lo}), 64'd0);
    check("midrst_ovf", 64'(bus.overflow), 64'd0);
    check("midrst_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_dones(25, dones);
    check("midrst_no_done", 64'(dones), 64'd0);
    @(posedge clk); #1;
    run_op(16'd7, 16'd9, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
